saes_req_scheduler: RTL and testbench

- Round-robin scheduler that shares one S-AES encryption core among NREQ independent requesters.
- Accepts one 16-bit plaintext at a time and launches the core with a single-cycle start pulse.
- Waits for the core's done pulse, with a watchdog, then returns the ciphertext tagged with the requester ID over a valid/ready response channel.
- Sits between the switch/host-side request sources and the S-AES core.

---
 rtl/saes_sched_pkg.sv | 14 +
 rtl/saes_req_scheduler_rr_arbiter.sv | 31 +++
 rtl/saes_req_scheduler.sv | 117 +++++++++++
 tb/tb_saes_req_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/saes_sched_pkg.sv
// Shared types and constants for the S-AES request scheduler.
package saes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int SAES_DW         = 16;
  localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/saes_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the last
// winner, so every requester is reached within NREQ-1 other grants.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);

  // First asserted index scanning ptr+1, ptr+2, ... modulo NREQ.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/saes_req_scheduler.sv
// Shares one S-AES core among NREQ requesters: round-robin accept, one-cycle
// launch, watchdog-guarded wait for done, tagged response over valid/ready.
module saes_req_scheduler
  import saes_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = SAES_DW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             core_start,
  output logic [DW-1:0]    core_pt,
  input  logic             core_done,
  input  logic [DW-1:0]    core_ct,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic [DW-1:0]    resp_data,
  output logic             resp_err,
  input  logic             resp_ready,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [DW-1:0]  data_q, data_d;
  logic           err_q, err_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .id    (grant_id)
  );

  // State, pointer, capture and watchdog registers; reset discards any
  // in-flight request and makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic; a done coinciding with the watchdog expiry wins.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ptr_d   = grant_id;
          id_d    = grant_id;
          data_d  = req_data[grant_id*DW +: DW];
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (core_done) begin
          data_d  = core_ct;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE) ? grant : '0;
  assign core_start = (state_q == ISSUE);
  assign core_pt    = data_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_saes_req_scheduler.sv
// Directed bench for saes_req_scheduler with a behavioural S-AES core model
// (ct = pt ^ 16'hA5A5 after a programmable latency; latency 0 = never done).
module tb_saes_req_scheduler;

  localparam int NREQ    = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 32;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             core_start;
  logic [DW-1:0]    core_pt;
  logic             core_done;
  logic [DW-1:0]    core_ct;
  logic             resp_valid;
  logic [1:0]       resp_id;
  logic [DW-1:0]    resp_data;
  logic             resp_err;
  logic             resp_ready;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;
  int n;

  // Core model state
  int          core_lat;
  logic        cd_act;
  logic [7:0]  cd_cnt;
  logic [15:0] cd_pt;
  logic        inj_done;
  logic [15:0] inj_ct;

  saes_req_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .core_start (core_start),
    .core_pt    (core_pt),
    .core_done  (core_done),
    .core_ct    (core_ct),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_act <= 1'b0;
      cd_cnt <= '0;
      cd_pt  <= '0;
    end else if (core_start && core_lat != 0) begin
      cd_act <= 1'b1;
      cd_cnt <= 8'(core_lat - 1);
      cd_pt  <= core_pt;
    end else if (cd_act) begin
      if (cd_cnt == 0) cd_act <= 1'b0;
      else             cd_cnt <= cd_cnt - 1'b1;
    end
  end

  assign core_done = (cd_act && cd_cnt == 0) || inj_done;
  assign core_ct   = inj_done ? inj_ct : (cd_pt ^ 16'hA5A5);

  always @(posedge clk) if (core_start) starts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Called in the core_start cycle; returns how many cycles until resp_valid.
  task automatic wait_resp(input string tag, output int cnt);
    cnt = 0;
    while (resp_valid !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_core_pt"},    32'(core_pt),    32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_id"},    32'(resp_id),    32'd0);
    chk({tag, "_resp_data"},  32'(resp_data),  32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    logic [3:0]  exp_gnt [5];
    logic [1:0]  exp_id  [5];
    logic [15:0] exp_ct  [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_ct  = '{16'hA5A4, 16'hA5A7, 16'hA5A6, 16'hA5A1, 16'hA5A4};

    rst_n = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0;
    core_lat = 5; inj_done = 1'b0; inj_ct = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Round robin with all four requesters valid
    req_data   = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(exp_gnt[g]));
      step();
      chk($sformatf("rr_start%0d", g), 32'(core_start), 32'd1);
      wait_resp($sformatf("rr_resp%0d", g), n);
      chk($sformatf("rr_id%0d", g),   32'(resp_id),   32'(exp_id[g]));
      chk($sformatf("rr_data%0d", g), 32'(resp_data), 32'(exp_ct[g]));
      chk($sformatf("rr_err%0d", g),  32'(resp_err),  32'd0);
      step();
    end
    req_valid = '0;
    #1;

    // Single request from requester 2
    req_data  = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    chk("single_start", 32'(core_start), 32'd1);
    chk("single_pt",    32'(core_pt),    32'h1234);
    chk("single_busy",  32'(busy),       32'd1);
    chk("single_nordy", 32'(req_ready),  32'd0);
    n = starts;
    step();
    chk("single_start_pulse", 32'(core_start), 32'd0);
    chk("single_start_count", 32'(starts - n), 32'd1);
    wait_resp("single_resp", n);
    chk("single_latency", 32'(n), 32'd5);
    chk("single_id",   32'(resp_id),   32'd2);
    chk("single_data", 32'(resp_data), 32'hB791);
    chk("single_err",  32'(resp_err),  32'd0);
    step();
    chk("single_idle_busy",  32'(busy),       32'd0);
    chk("single_idle_valid", 32'(resp_valid), 32'd0);

    // Watchdog timeout: core never answers
    core_lat  = 0;
    req_data  = {16'h0000, 16'h0000, 16'h0000, 16'h5555};
    req_valid = 4'b0001;
    #1;
    chk("to_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    chk("to_start", 32'(core_start), 32'd1);
    wait_resp("to_resp", n);
    chk("to_latency", 32'(n), 32'(TIMEOUT + 1));
    chk("to_err",  32'(resp_err),  32'd1);
    chk("to_data", 32'(resp_data), 32'd0);
    chk("to_id",   32'(resp_id),   32'd0);
    step();
    chk("to_idle", 32'(busy), 32'd0);
    inj_ct   = 16'hBEEF;
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("late_done_valid%0d", k), 32'(resp_valid), 32'd0);
      chk($sformatf("late_done_busy%0d", k),  32'(busy),       32'd0);
      step();
    end

    // Response back-pressure
    core_lat   = 5;
    resp_ready = 1'b0;
    req_data   = {16'h0F0F, 16'h0000, 16'h0000, 16'h0000};
    req_valid  = 4'b1000;
    #1;
    chk("hold_ready", 32'(req_ready), 32'b1000);
    step();
    chk("hold_start", 32'(core_start), 32'd1);
    req_valid = 4'b1111;
    wait_resp("hold_resp", n);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold_valid%0d", k), 32'(resp_valid), 32'd1);
      chk($sformatf("hold_id%0d", k),    32'(resp_id),    32'd3);
      chk($sformatf("hold_data%0d", k),  32'(resp_data),  32'hAAAA);
      chk($sformatf("hold_nordy%0d", k), 32'(req_ready),  32'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("hold_release_idle", 32'(resp_valid), 32'd0);
    chk("hold_next_grant",   32'(req_ready),  32'b0001);
    req_valid = '0;
    #1;

    // Asynchronous reset while waiting on the core
    core_lat  = 0;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h00FF};
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("arst_start", 32'(core_start), 32'd1);
    step();
    step();
    chk("arst_in_wait", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    core_lat  = 5;
    req_valid = 4'b1111;
    #1;
    chk("arst_first_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    chk("arst_start2", 32'(core_start), 32'd1);
    wait_resp("arst_resp", n);
    chk("arst_latency", 32'(n), 32'd6);
    chk("arst_id",   32'(resp_id),   32'd0);
    chk("arst_data", 32'(resp_data), 32'hA55A);
    step();

    // core_done on the last watchdog cycle
    core_lat  = TIMEOUT;
    req_data  = {16'h0000, 16'h0000, 16'h1357, 16'h0000};
    req_valid = 4'b0010;
    #1;
    chk("coin_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    wait_resp("coin_resp", n);
    chk("coin_latency", 32'(n), 32'(TIMEOUT + 1));
    chk("coin_err",  32'(resp_err),  32'd0);
    chk("coin_data", 32'(resp_data), 32'hB6F2);
    chk("coin_id",   32'(resp_id),   32'd1);
    step();
    chk("coin_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
